// File: rtl/fifo_write_ctrl_if.sv
// Bus between the FIFO writer and the write controller. Request/response contract:
// wr_en is a request sampled each edge; the next cycle carries exactly one of wr_ack/wr_err.
interface fifo_write_ctrl_if;
  logic        wr_en;
  logic [31:0] din;
  logic        rd_ack;
  logic [31:0] to_reg0;
  logic [31:0] to_reg1;
  logic [31:0] to_reg2;
  logic [31:0] to_reg3;
  logic [31:0] to_reg4;
  logic [31:0] to_reg5;
  logic [31:0] to_reg6;
  logic [31:0] to_reg7;
  logic [2:0]  wr_ptr;
  logic [3:0]  data_count;
  logic        full;
  logic        empty;
  logic        wr_ack;
  logic        wr_err;
  logic [1:0]  state;

  modport master (
    output wr_en, din, rd_ack,
    input  to_reg0, to_reg1, to_reg2, to_reg3, to_reg4, to_reg5, to_reg6, to_reg7,
    input  wr_ptr, data_count, full, empty, wr_ack, wr_err, state
  );

  modport slave (
    input  wr_en, din, rd_ack,
    output to_reg0, to_reg1, to_reg2, to_reg3, to_reg4, to_reg5, to_reg6, to_reg7,
    output wr_ptr, data_count, full, empty, wr_ack, wr_err, state
  );
endinterface

// File: rtl/fifo_write_ctrl.sv
// Write side of an 8 x 32 FIFO: storage registers, write pointer, occupancy count
// and a small request-status FSM whose state is exported for observation.
module fifo_write_ctrl (
  input  logic            clk,
  input  logic            reset_n,
  fifo_write_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WRITE    = 2'b01,
    WR_ERROR = 2'b10
  } state_t;

  logic [31:0] regs [8];
  logic [2:0]  wr_ptr_q;
  logic [3:0]  count_q;
  logic        ack_q;
  logic        err_q;
  state_t      state_q;

  logic        full_c;
  logic        empty_c;
  logic        wr_ok;
  logic        rd_ok;
  logic [7:0]  wr_sel;

  assign full_c  = (count_q == 4'd8);
  assign empty_c = (count_q == 4'd0);
  // Full is judged on the pre-edge count, so a same-cycle read never rescues a write.
  assign wr_ok   = bus.wr_en && !full_c;
  assign rd_ok   = bus.rd_ack && !empty_c;

  always_comb begin
    wr_sel = '0;
    if (wr_ok) wr_sel[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_sel[i]) regs[i] <= bus.din;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      state_q  <= IDLE;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 3'd1;

      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase

      if (!bus.wr_en) begin
        state_q <= IDLE;
        ack_q   <= 1'b0;
        err_q   <= 1'b0;
      end else if (full_c) begin
        state_q <= WR_ERROR;
        ack_q   <= 1'b0;
        err_q   <= 1'b1;
      end else begin
        state_q <= WRITE;
        ack_q   <= 1'b1;
        err_q   <= 1'b0;
      end
    end
  end

  assign bus.to_reg0    = regs[0];
  assign bus.to_reg1    = regs[1];
  assign bus.to_reg2    = regs[2];
  assign bus.to_reg3    = regs[3];
  assign bus.to_reg4    = regs[4];
  assign bus.to_reg5    = regs[5];
  assign bus.to_reg6    = regs[6];
  assign bus.to_reg7    = regs[7];
  assign bus.wr_ptr     = wr_ptr_q;
  assign bus.data_count = count_q;
  assign bus.full       = full_c;
  assign bus.empty      = empty_c;
  assign bus.wr_ack     = ack_q;
  assign bus.wr_err     = err_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed bench for fifo_write_ctrl: stimulus pushes hand-computed expected
// output snapshots; an independent monitor pops and compares them.
module tb_fifo_write_ctrl;
  localparam int W = 269;

  logic clk;
  logic reset_n;

  fifo_write_ctrl_if bus ();

  fifo_write_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [31:0]  exp_regs [8];
  int           n_cmp;
  int           n_err;
  event         chk_ev;

  function automatic logic [W-1:0] pack_exp(input logic [2:0] ptr, input logic [3:0] cnt,
                                            input logic ack, input logic err,
                                            input logic [1:0] st);
    return {exp_regs[7], exp_regs[6], exp_regs[5], exp_regs[4],
            exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0],
            ptr, cnt, (cnt == 4'd8), (cnt == 4'd0), ack, err, st};
  endfunction

  function automatic logic [W-1:0] pack_obs();
    return {bus.to_reg7, bus.to_reg6, bus.to_reg5, bus.to_reg4,
            bus.to_reg3, bus.to_reg2, bus.to_reg1, bus.to_reg0,
            bus.wr_ptr, bus.data_count, bus.full, bus.empty,
            bus.wr_ack, bus.wr_err, bus.state};
  endfunction

  // Monitor: compares after each rising edge, or mid-cycle on demand for async reset
  initial begin
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (exp_q.size() > 0) begin
        logic [W-1:0] e;
        logic [W-1:0] o;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        o  = pack_obs();
        n_cmp++;
        if (o !== e) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", nm, o, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic step(input logic we, input logic [31:0] d, input logic ra,
                      input logic [2:0] e_ptr, input logic [3:0] e_cnt,
                      input logic e_ack, input logic e_err, input logic [1:0] e_st,
                      input int e_idx, input string nm);
    @(negedge clk);
    bus.wr_en  = we;
    bus.din    = d;
    bus.rd_ack = ra;
    if (e_idx >= 0) exp_regs[e_idx] = d;
    exp_q.push_back(pack_exp(e_ptr, e_cnt, e_ack, e_err, e_st));
    name_q.push_back(nm);
  endtask

  task automatic assert_reset_mid_cycle(input string nm);
    @(negedge clk);
    bus.wr_en  = 1'b0;
    bus.rd_ack = 1'b0;
    #2;
    reset_n = 1'b0;
    for (int i = 0; i < 8; i++) exp_regs[i] = '0;
    exp_q.push_back(pack_exp(3'd0, 4'd0, 1'b0, 1'b0, 2'b00));
    name_q.push_back(nm);
    -> chk_ev;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    bus.wr_en  = 1'b0;
    bus.din    = '0;
    bus.rd_ack = 1'b0;
    for (int i = 0; i < 8; i++) exp_regs[i] = '0;

    // Initial asynchronous reset, checked before the first clock edge
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    exp_q.push_back(pack_exp(3'd0, 4'd0, 1'b0, 1'b0, 2'b00));
    name_q.push_back("reset_async");
    -> chk_ev;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Fill 8 entries back-to-back, including pointer wrap 7 -> 0
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'hA000_0000 + i, 1'b0, 3'((i + 1) % 8), 4'(i + 1),
           1'b1, 1'b0, 2'b01, i, $sformatf("fill_%0d", i));
    end

    // Write while full: rejected, registers untouched
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 3'd0, 4'd8, 1'b0, 1'b1, 2'b10, -1, "reject_full");
    step(1'b0, 32'h0,         1'b0, 3'd0, 4'd8, 1'b0, 1'b0, 2'b00, -1, "idle_after_err");

    // Full with simultaneous read: still rejected, count drops to 7
    step(1'b1, 32'hB000_0001, 1'b1, 3'd0, 4'd7, 1'b0, 1'b1, 2'b10, -1, "reject_with_rd");
    step(1'b1, 32'hB000_0002, 1'b0, 3'd1, 4'd8, 1'b1, 1'b0, 2'b01,  0, "refill_reg0");

    // Drain to 3
    step(1'b0, 32'h0, 1'b1, 3'd1, 4'd7, 1'b0, 1'b0, 2'b00, -1, "drain_7");
    step(1'b0, 32'h0, 1'b1, 3'd1, 4'd6, 1'b0, 1'b0, 2'b00, -1, "drain_6");
    step(1'b0, 32'h0, 1'b1, 3'd1, 4'd5, 1'b0, 1'b0, 2'b00, -1, "drain_5");
    step(1'b0, 32'h0, 1'b1, 3'd1, 4'd4, 1'b0, 1'b0, 2'b00, -1, "drain_4");
    step(1'b0, 32'h0, 1'b1, 3'd1, 4'd3, 1'b0, 1'b0, 2'b00, -1, "drain_3");

    // Write and read together at count 3: count holds, pointer advances
    step(1'b1, 32'hC000_0003, 1'b1, 3'd2, 4'd3, 1'b1, 1'b0, 2'b01, 1, "wr_rd_same");

    // Drain to empty, then read at empty twice (ignored)
    step(1'b0, 32'h0, 1'b1, 3'd2, 4'd2, 1'b0, 1'b0, 2'b00, -1, "drain_2");
    step(1'b0, 32'h0, 1'b1, 3'd2, 4'd1, 1'b0, 1'b0, 2'b00, -1, "drain_1");
    step(1'b0, 32'h0, 1'b1, 3'd2, 4'd0, 1'b0, 1'b0, 2'b00, -1, "drain_0");
    step(1'b0, 32'h0, 1'b1, 3'd2, 4'd0, 1'b0, 1'b0, 2'b00, -1, "rd_empty_a");
    step(1'b0, 32'h0, 1'b1, 3'd2, 4'd0, 1'b0, 1'b0, 2'b00, -1, "rd_empty_b");

    // Write with read at empty: read ignored, count goes to 1
    step(1'b1, 32'hD000_0000, 1'b1, 3'd3, 4'd1, 1'b1, 1'b0, 2'b01, 2, "wr_rd_empty");

    // Five writes after a fresh reset, then reset between edges
    assert_reset_mid_cycle("reset_before_burst");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'hE000_0000 + i, 1'b0, 3'(i + 1), 4'(i + 1),
           1'b1, 1'b0, 2'b01, i, $sformatf("burst_%0d", i));
    end
    assert_reset_mid_cycle("reset_mid_burst");

    // First write after reset lands in to_reg0
    step(1'b1, 32'hF000_0000, 1'b0, 3'd1, 4'd1, 1'b1, 1'b0, 2'b01, 0, "first_after_reset");
    step(1'b0, 32'h0,         1'b0, 3'd1, 4'd1, 1'b0, 1'b0, 2'b00, -1, "ack_one_cycle");

    @(negedge clk);
    bus.wr_en  = 1'b0;
    bus.rd_ack = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
